// File: rtl/offset_stream_uram_pkg.sv
// ---------------------------------------------------------------------------
// offset_stream_uram_pkg
// Shared definitions for the offset stream loader:
//   - load_state_t : load FSM states (IDLE, LOAD, UNPACK, DONE)
//   - off_pair_t   : one {loff, roff} entry at the default offset width
//   - DEF_V_OFF_AWIDTH / DEF_V_OFF_DWIDTH : default address / offset widths
//   - idx_width()  : width of an index over n items, never below 1 bit
// ---------------------------------------------------------------------------
package offset_stream_uram_pkg;

  localparam int DEF_V_OFF_AWIDTH = 10;
  localparam int DEF_V_OFF_DWIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UNPACK = 2'd2,
    ST_DONE   = 2'd3
  } load_state_t;

  // Entry layout inside an HBM beat: left offset in the upper half.
  typedef struct packed {
    logic [DEF_V_OFF_DWIDTH-1:0] loff;
    logic [DEF_V_OFF_DWIDTH-1:0] roff;
  } off_pair_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/offset_stream_uram_pipe.sv
// ---------------------------------------------------------------------------
// off_uram_pipe
// Read-first single-port UltraRAM with an NBPIPE-stage output pipeline.
// Each pipeline stage only advances when its enable is set, so the caller
// drives the enables from its own read-valid pipeline.
// Ports:
//   clk      in   clock
//   en       in   port enable (read or write)
//   we       in   write enable (qualified by en)
//   addr     in   [AWIDTH-1:0] entry address
//   din      in   [DWIDTH-1:0] write data
//   pipe_en  in   [NBPIPE-1:0] per-stage output pipeline enables
//   dout     out  [DWIDTH-1:0] last pipeline stage
// ---------------------------------------------------------------------------
module off_uram_pipe #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 64,
  parameter int NBPIPE = 3
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] din,
  input  logic [NBPIPE-1:0] pipe_en,
  output logic [DWIDTH-1:0] dout
);

  localparam int DEPTH = 1 << AWIDTH;

  (* ram_style = "ultra" *)
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] mem_q;
  logic [DWIDTH-1:0] pipe_q [NBPIPE];

  // NOTE: no reset here -- RAM arrays cannot be reset in hardware, and the
  // data pipe is qualified by the caller's valid pipeline, so stale data is
  // never observed as valid.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q <= mem[addr];  // read-first: old contents on a write cycle
      if (we) begin
        mem[addr] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pipe_en[0]) begin
      pipe_q[0] <= mem_q;
    end
    for (int i = 1; i < NBPIPE; i++) begin
      if (pipe_en[i]) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[NBPIPE-1];

endmodule

// File: rtl/offset_stream_uram.sv
// ---------------------------------------------------------------------------
// offset_stream_uram
// Loads LOAD_ENTRIES {loffset, roffset} pairs from a packed HBM beat stream
// into an UltraRAM, then serves indexed reads with a fixed latency of
// NBPIPE+2 cycles from acceptance to dvalid.
//
// Build option: define OFFSET_RD_BLOCK_EN to accept reads only once the load
// has completed (DONE). Without it, reads are accepted in IDLE, LOAD and DONE
// and return whatever the memory currently holds. Reads are never accepted in
// UNPACK, where the writer owns the single memory port.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   load_start         one-cycle pulse, starts (or restarts from DONE) a load
//   hbm_data/valid     packed beat in, entry k at [(k+1)*2W-1 : k*2W] = {l,r}
//   hbm_ready          beat accept, high only in LOAD
//   rd_addr/rd_valid   read request; rd_ready accept
//   loffset/roffset    read data, held between reads; dvalid marks new data
//   transfer_complete  level, high in DONE
//   load_count         entries written in the current load
// ---------------------------------------------------------------------------
module offset_stream_uram
  import offset_stream_uram_pkg::*;
#(
  parameter int V_OFF_AWIDTH     = DEF_V_OFF_AWIDTH,
  parameter int V_OFF_DWIDTH     = DEF_V_OFF_DWIDTH,
  parameter int ENTRIES_PER_BEAT = 4,
  parameter int LOAD_ENTRIES     = 1024,
  parameter int NBPIPE           = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      load_start,
  input  logic [ENTRIES_PER_BEAT*2*V_OFF_DWIDTH-1:0] hbm_data,
  input  logic                                      hbm_valid,
  output logic                                      hbm_ready,
  input  logic [V_OFF_AWIDTH-1:0]                   rd_addr,
  input  logic                                      rd_valid,
  output logic                                      rd_ready,
  output logic [V_OFF_DWIDTH-1:0]                   loffset,
  output logic [V_OFF_DWIDTH-1:0]                   roffset,
  output logic                                      dvalid,
  output logic                                      transfer_complete,
  output logic [V_OFF_AWIDTH:0]                     load_count
);

  localparam int PAIR_W = 2 * V_OFF_DWIDTH;
  localparam int BEAT_W = ENTRIES_PER_BEAT * PAIR_W;
  localparam int IDX_W  = idx_width(ENTRIES_PER_BEAT);

  localparam logic [V_OFF_AWIDTH:0] LOAD_MAX = (V_OFF_AWIDTH+1)'(LOAD_ENTRIES);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(ENTRIES_PER_BEAT - 1);

`ifdef OFFSET_RD_BLOCK_EN
  localparam bit RD_OPEN = 1'b0;  // reads only in DONE
`else
  localparam bit RD_OPEN = 1'b1;  // reads also in IDLE and LOAD
`endif

  load_state_t state, state_next;

  logic [BEAT_W-1:0]       beat_q;
  logic [IDX_W-1:0]        entry_idx;
  logic [PAIR_W-1:0]       cur_entry;
  logic [V_OFF_AWIDTH:0]   count_inc;
  logic                    mem_we;
  logic                    rd_accept;
  logic [V_OFF_AWIDTH-1:0] mem_addr;
  logic [NBPIPE:0]         vld;       // vld[i]: read data sits in stage i
  logic [PAIR_W-1:0]       mem_dout;

  assign count_inc = load_count + 1'b1;
  assign rd_accept = rd_valid && rd_ready;

  // ---------------- load FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- load FSM: next state and control ----------------
  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    hbm_ready  = 1'b0;
    rd_ready   = 1'b0;
    mem_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        rd_ready = RD_OPEN;
        if (load_start) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        hbm_ready = 1'b1;
        rd_ready  = RD_OPEN;
        if (hbm_valid) begin
          state_next = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        // The count guard keeps load_count saturated at LOAD_ENTRIES.
        mem_we = (load_count < LOAD_MAX);
        if (!mem_we || count_inc == LOAD_MAX) begin
          state_next = ST_DONE;  // rest of a partial final beat is dropped
        end else if (entry_idx == LAST_IDX) begin
          state_next = ST_LOAD;
        end
      end
      ST_DONE: begin
        rd_ready = 1'b1;
        if (load_start) begin
          state_next = ST_LOAD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign transfer_complete = (state == ST_DONE);

  // ---------------- unpacker ----------------
  always_comb begin
    cur_entry = '0;
    for (int k = 0; k < ENTRIES_PER_BEAT; k++) begin
      if (entry_idx == IDX_W'(k)) begin
        cur_entry = beat_q[k*PAIR_W +: PAIR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_count <= '0;
      entry_idx  <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (hbm_valid) begin
            entry_idx <= '0;
          end
        end
        ST_UNPACK: begin
          if (mem_we) begin
            load_count <= count_inc;
            entry_idx  <= entry_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (load_start) begin
            load_count <= '0;  // reload restarts the count on the same edge
          end
        end
        default: ;
      endcase
    end
  end

  // The beat register is only read in UNPACK, after a capture.
  always_ff @(posedge clk) begin
    if (hbm_valid && hbm_ready) begin
      beat_q <= hbm_data;
    end
  end

  // ---------------- memory ----------------
  assign mem_addr = mem_we ? load_count[V_OFF_AWIDTH-1:0] : rd_addr;

  off_uram_pipe #(
    .AWIDTH (V_OFF_AWIDTH),
    .DWIDTH (PAIR_W),
    .NBPIPE (NBPIPE)
  ) u_mem (
    .clk     (clk),
    .en      (mem_we || rd_accept),
    .we      (mem_we),
    .addr    (mem_addr),
    .din     (cur_entry),
    .pipe_en (vld[NBPIPE-1:0]),
    .dout    (mem_dout)
  );

  // ---------------- read-valid pipeline and output register ----------------
  // Latency: memory register, NBPIPE pipe stages, output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= '0;
      dvalid  <= 1'b0;
      loffset <= '0;
      roffset <= '0;
    end else begin
      vld    <= {vld[NBPIPE-1:0], rd_accept};
      dvalid <= vld[NBPIPE];
      if (vld[NBPIPE]) begin
        loffset <= mem_dout[PAIR_W-1:V_OFF_DWIDTH];
        roffset <= mem_dout[V_OFF_DWIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/offset_stream_uram.md
OFFSET_STREAM_URAM -- requirements
Module: offset_stream_uram

Interface
REQ-001 SHALL have parameter V_OFF_AWIDTH, default 10, meaning entry address width; depth is 2^V_OFF_AWIDTH.
REQ-002 SHALL have parameter V_OFF_DWIDTH, default 32, meaning width of one offset.
REQ-003 SHALL have parameter ENTRIES_PER_BEAT, default 4, meaning {loffset,roffset} entries packed in one HBM beat; legal range 1..8.
REQ-004 SHALL have parameter LOAD_ENTRIES, default 1024, meaning entries loaded per load; range 1..2^V_OFF_AWIDTH.
REQ-005 SHALL have parameter NBPIPE, default 3, meaning memory output pipeline stages; minimum 1.
REQ-006 SHALL have these ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- load_start  in  1  one-cycle pulse that starts a load.
- hbm_data  in  ENTRIES_PER_BEAT*2*V_OFF_DWIDTH  packed beat; entry k sits at bits [(k+1)*2W-1 : k*2W] as {loff,roff}.
- hbm_valid  in  1  beat valid.
- hbm_ready  out  1  beat accept.
- rd_addr  in  V_OFF_AWIDTH  read entry index.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accept.
- loffset  out  V_OFF_DWIDTH  read left offset.
- roffset  out  V_OFF_DWIDTH  read right offset.
- dvalid  out  1  read data valid.
- transfer_complete  out  1  load finished, level signal.
- load_count  out  V_OFF_AWIDTH+1  number of entries written so far.

Function
REQ-007 SHALL implement a load FSM with states IDLE, LOAD, UNPACK, DONE.
REQ-008 IDLE -> LOAD on load_start; DONE -> LOAD on load_start (reload) clears transfer_complete and load_count the same cycle; load_start in LOAD or UNPACK SHALL be ignored.
REQ-009 hbm_ready SHALL be 1 only in LOAD; a beat SHALL transfer when hbm_valid && hbm_ready, be captured into an unpack register, and move the FSM LOAD -> UNPACK.
REQ-010 UNPACK SHALL write one entry per cycle, lowest k first, to address load_count, incrementing load_count per write.
REQ-011 UNPACK SHALL go to LOAD after the last entry of a beat, or to DONE as soon as load_count reaches LOAD_ENTRIES; remaining entries of a partial final beat SHALL be discarded.
REQ-012 DONE SHALL assert transfer_complete; beats SHALL NOT be accepted in DONE or IDLE.
REQ-013 A read SHALL be accepted when rd_valid && rd_ready; loffset/roffset SHALL be valid with dvalid exactly NBPIPE+2 cycles later (5 at default), one dvalid per accepted read, in order.
REQ-014 Writes SHALL own the memory port; in UNPACK rd_ready SHALL be 0 in every build.
REQ-015 The memory SHALL be read-first single-port; outputs SHALL hold their last value when dvalid is 0.
REQ-016 load_count SHALL saturate at LOAD_ENTRIES; rd_addr >= LOAD_ENTRIES SHALL return undefined data but a normal dvalid.

Reset
REQ-017 rst SHALL force state IDLE, hbm_ready 0, transfer_complete 0, load_count 0, dvalid 0, and clear all read-valid pipeline stages, including mid-load and mid-read; loffset/roffset SHALL reset to 0; memory contents are not cleared.

Configuration
REQ-018 With OFFSET_RD_BLOCK_EN defined, rd_ready SHALL be 1 only in DONE.
REQ-019 Without OFFSET_RD_BLOCK_EN, rd_ready SHALL be 1 in IDLE, LOAD and DONE, and return current (possibly stale) contents.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, the entry-pair typedef {loff,roff}, and default constants for V_OFF_AWIDTH and V_OFF_DWIDTH.
REQ-021 A sub-module off_uram_pipe (read-first UltraRAM with NBPIPE-stage enable-qualified output pipe) SHALL hold the memory; FSM, unpacker and valid pipeline stay in the top.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Load pulse, LOAD_ENTRIES=8, E=4, two beats with entry n={n,n+1} -> transfer_complete rises after the 8th write; load_count=8.
- After the load, read addr 5 -> dvalid 5 cycles later with loffset=5, roffset=6.
- LOAD_ENTRIES=6, two beats -> entries 6,7 discarded, DONE at count 6, second beat is the last accepted.
- hbm_valid held in DONE -> hbm_ready stays 0 and load_count is unchanged.
- rst asserted in UNPACK at count 3 -> next cycle IDLE, count 0, dvalid 0; a new load then completes normally.
- rd_valid during LOAD: with OFFSET_RD_BLOCK_EN, rd_ready=0 and no dvalid; without it, dvalid after 5 cycles.
